// File: rtl/timer_dev_pkg.sv
// Shared definitions for the countdown timer device: state encoding,
// register offsets, CTRL field positions and counting modes.
package timer_dev_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word offsets inside the device window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL field positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // Only the low four CTRL bits exist; the rest read as zero
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;

  // Counting modes (2 and 3 fall back to one-shot)
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Byte-lane merge: lanes with their enable set take the new data
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Bridge-side bus of the timer device: write strobe, byte enables, word
// offset and store data in; read data and interrupt request out.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  // Bridge side
  modport master (output addr, output we, output be, output din,
                  input dout, input irq);

  // Timer side
  modport slave  (input addr, input we, input be, input din,
                  output dout, output irq);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// CTRL/PRESET are byte-writable, COUNT is read-only, and a level interrupt
// (IRQF masked by IM) is acknowledged by any write to CTRL or PRESET.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  timer_dev_if.slave bus
);

  state_t      state_reg, state_next;
  logic [31:0] ctrl_reg, ctrl_next;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;
  logic        irqf_reg, irqf_next;

  logic [31:0] ctrl_base;
  logic [1:0]  mode;
  logic        wr_ctrl, wr_preset, ack;
  logic        set_irqf, clr_irqf_int;

  assign mode      = ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign wr_ctrl   = bus.we && (bus.addr == OFF_CTRL);
  assign wr_preset = bus.we && (bus.addr == OFF_PRESET);
  // An all-zero byte enable is not a write and therefore not an acknowledge
  assign ack       = (wr_ctrl || wr_preset) && (|bus.be);

  // Sequencer, counter and register next-state; bus writes applied last so
  // they override the sequencer's own EN clear on written bytes
  always_comb begin
    state_next   = state_reg;
    ctrl_base    = ctrl_reg;
    count_next   = count_reg;
    preset_next  = preset_reg;
    irqf_next    = irqf_reg;
    set_irqf     = 1'b0;
    clr_irqf_int = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ctrl_reg[CTRL_EN]) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // The load completes even if EN was just cleared
        count_next = preset_reg;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_reg[CTRL_EN]) begin
          state_next = ST_IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          // Saturate at zero; a preset of 0 expires immediately
          count_next = 32'd0;
          set_irqf   = 1'b1;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        state_next = ST_IDLE;
        case (mode)
          MODE_RELOAD:  clr_irqf_int = 1'b1;
          MODE_ONESHOT: ctrl_base[CTRL_EN] = 1'b0;
          default:      ctrl_base[CTRL_EN] = 1'b0;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_next = be_merge(ctrl_base, bus.din, bus.be) & CTRL_MASK;
    end else begin
      ctrl_next = ctrl_base;
    end

    if (wr_preset) begin
      preset_next = be_merge(preset_reg, bus.din, bus.be);
    end

    // Expiry beats a simultaneous acknowledge so no interrupt is lost
    if (set_irqf) begin
      irqf_next = 1'b1;
    end else if (ack || clr_irqf_int) begin
      irqf_next = 1'b0;
    end
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ctrl_reg   <= 32'd0;
      preset_reg <= 32'd0;
      count_reg  <= 32'd0;
      irqf_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= ctrl_next;
      preset_reg <= preset_next;
      count_reg  <= count_next;
      irqf_reg   <= irqf_next;
    end
  end

  // Combinational read mux; offset 3 reads zero
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      OFF_CTRL:   bus.dout = ctrl_reg;
      OFF_PRESET: bus.dout = preset_reg;
      OFF_COUNT:  bus.dout = count_reg;
      default:    bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = irqf_reg & ctrl_reg[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev: reset defaults, one-shot, auto-reload,
// masking, pause/byte writes, INT-cycle collision, set-vs-ack and reset.
module tb_timer_dev;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  timer_dev_if bus_if ();

  timer_dev dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational read within the current cycle
  task automatic chk_reg(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    chk(tag, bus_if.dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, bus_if.irq}, {31'd0, exp});
  endtask

  // One-cycle bus write; returns in the following cycle
  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    bus_if.addr = a;
    bus_if.din  = d;
    bus_if.be   = b;
    bus_if.we   = 1'b1;
    tick();
    bus_if.we   = 1'b0;
    bus_if.be   = 4'h0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus_if.addr = 2'd0;
    bus_if.we   = 1'b0;
    bus_if.be   = 4'h0;
    bus_if.din  = 32'd0;

    // Reset defaults
    ticks(2);
    rst = 1'b0;
    chk_reg("rst_ctrl",   2'd0, 32'd0);
    chk_reg("rst_preset", 2'd1, 32'd0);
    chk_reg("rst_count",  2'd2, 32'd0);
    chk_reg("rst_rsvd",   2'd3, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET=5, CTRL=0x9 written in cycle t
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);              // now in t+1
    ticks(2);                           // t+3
    chk_reg("os_count_t3", 2'd2, 32'd5);
    chk_irq("os_irq_t3", 1'b0);
    ticks(4);                           // t+7
    chk_reg("os_count_t7", 2'd2, 32'd1);
    chk_irq("os_irq_t7", 1'b0);
    tick();                             // t+8
    chk_irq("os_irq_t8", 1'b1);
    chk_reg("os_count_t8", 2'd2, 32'd0);
    tick();                             // t+9
    chk_reg("os_ctrl_after", 2'd0, 32'h8);
    ticks(3);
    chk_irq("os_irq_held", 1'b1);
    wr(2'd0, 32'h8, 4'hF);
    chk_irq("os_irq_ack", 1'b0);

    // Auto-reload, PRESET=3, CTRL=0xB: pulses every 6 cycles
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'hB, 4'hF);              // now in t+1
    for (int k = 1; k <= 30; k++) begin
      chk_irq($sformatf("ar_irq_k%0d", k), (k % 6) == 0);
      tick();
    end
    wr(2'd0, 32'h0, 4'hF);
    ticks(4);
    chk_irq("ar_stopped_irq", 1'b0);
    chk_reg("ar_stopped_ctrl", 2'd0, 32'h0);

    // Mask: one-shot, IM=0, PRESET=2
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);              // t+1
    for (int k = 1; k <= 8; k++) begin
      chk_irq($sformatf("mask_irq_k%0d", k), 1'b0);
      tick();
    end
    chk_reg("mask_ctrl_done", 2'd0, 32'h0);
    wr(2'd0, 32'h8, 4'hF);
    chk_irq("mask_irq_after_im", 1'b0);

    // Pause and byte writes, PRESET=100
    wr(2'd1, 32'd100, 4'hF);
    wr(2'd0, 32'h1, 4'hF);              // t+1
    ticks(2);                           // t+3
    chk_reg("pause_count_t3", 2'd2, 32'd100);
    ticks(10);                          // t+13
    chk_reg("pause_count_t13", 2'd2, 32'd90);
    wr(2'd0, 32'h0, 4'hF);              // t+14, last decrement at end of t+13
    chk_reg("pause_frozen", 2'd2, 32'd89);
    ticks(3);
    chk_reg("pause_frozen_later", 2'd2, 32'd89);
    wr(2'd2, 32'h1234_5678, 4'hF);
    chk_reg("count_write_ignored", 2'd2, 32'd89);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    chk_reg("rsvd_reads_zero", 2'd3, 32'd0);
    wr(2'd1, 32'h0000_AB00, 4'b0010);
    chk_reg("preset_byte1", 2'd1, 32'h0000_AB64);
    wr(2'd0, 32'hFFFF_FF06, 4'b0001);
    chk_reg("ctrl_upper_ignored", 2'd0, 32'h6);
    wr(2'd0, 32'h0, 4'hF);

    // Collision: CTRL=0x1 written in the INT cycle (PRESET=2, INT at t+5)
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);              // t+1
    ticks(4);                           // t+5
    chk_reg("col_count_int", 2'd2, 32'd0);
    wr(2'd0, 32'h1, 4'hF);              // t+6
    chk_reg("col_ctrl_bus_wins", 2'd0, 32'h1);
    chk_irq("col_irq_masked", 1'b0);
    ticks(2);                           // t+8
    chk_reg("col_restart_count", 2'd2, 32'd2);
    wr(2'd0, 32'h0, 4'hF);
    ticks(4);

    // Expiry coincident with a PRESET write: set wins (PRESET=3, INT at t+6)
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);              // t+1
    ticks(4);                           // t+5, last CNT cycle
    wr(2'd1, 32'd3, 4'hF);              // t+6
    chk_irq("setwins_irq_int", 1'b1);
    tick();                             // t+7
    chk_irq("setwins_irq_held", 1'b1);
    chk_reg("setwins_ctrl", 2'd0, 32'h8);

    // Reset while irq is pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_irq("rst2_irq", 1'b0);
    chk_reg("rst2_ctrl",   2'd0, 32'd0);
    chk_reg("rst2_preset", 2'd1, 32'd0);
    chk_reg("rst2_count",  2'd2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
